// File: rtl/bus_rx_framer_pkg.sv
// Shared definitions for the bus receive framer.
//   - bus_rx_state_e     : framer state encoding
//   - ST_*               : legacy-style 3-bit state constants that mirror the enum
//   - I3C_BROADCAST_ADDR : default broadcast address (7'h7E)
package bus_rx_framer_pkg;

  localparam logic [6:0] I3C_BROADCAST_ADDR = 7'h7E;

  typedef enum logic [2:0] {
    BRX_IDLE   = 3'd0,
    BRX_ADDR   = 3'd1,
    BRX_DATA   = 3'd2,
    BRX_NINTH  = 3'd3,
    BRX_IGNORE = 3'd4
  } bus_rx_state_e;

  localparam logic [2:0] ST_IDLE   = BRX_IDLE;
  localparam logic [2:0] ST_ADDR   = BRX_ADDR;
  localparam logic [2:0] ST_DATA   = BRX_DATA;
  localparam logic [2:0] ST_NINTH  = BRX_NINTH;
  localparam logic [2:0] ST_IGNORE = BRX_IGNORE;

endpackage

// File: rtl/bus_rx_framer_if.sv
// Byte delivery channel from the framer to the target FSM.
//   rx_byte_o    : received byte
//   rx_is_addr_o : byte is the address byte following a START
//   rx_valid_o   : byte available
//   rx_ready_i   : consumer accepts the byte
// master = framer side, slave = consumer side.
interface bus_rx_framer_if;
  logic [7:0] rx_byte_o;
  logic       rx_is_addr_o;
  logic       rx_valid_o;
  logic       rx_ready_i;

  modport master (output rx_byte_o, output rx_is_addr_o, output rx_valid_o, input rx_ready_i);
  modport slave  (input rx_byte_o, input rx_is_addr_o, input rx_valid_o, output rx_ready_i);
endinterface

// File: rtl/bus_rx_framer.sv
// Bus receive framer: deserializes SDR frames MSB-first from synchronized
// SCL/SDA, classifies the first byte after START as the address byte,
// matches it against own_addr_i and BROADCAST_ADDR, reports the 9th bit and
// hands bytes to the target FSM over a valid/ready channel.
// Ports:
//   clk_i, rst_ni                 : clock, async active-low reset
//   enable_i                      : low forces IDLE
//   scl_i, sda_i                  : synchronized bus lines
//   start_detect_i, stop_detect_i : bus monitor pulses
//   own_addr_i, own_addr_valid_i  : target address
//   rx_if (master)                : byte channel
//   addr_match_o, rnw_o           : address match level and R/W bit
//   ninth_valid_o, ninth_bit_o    : 9th bit pulse and value
//   frame_error_o                 : START/STOP inside a byte (pulse)
//   overflow_o, overflow_clr_i    : sticky dropped-byte flag and its clear
//   parity_err_o                  : only with BUS_RX_FRAMER_PARITY_CHECK_EN
// Optional feature macro: BUS_RX_FRAMER_PARITY_CHECK_EN (T-bit odd parity check).
module bus_rx_framer
  import bus_rx_framer_pkg::*;
#(
  parameter logic [6:0] BROADCAST_ADDR = I3C_BROADCAST_ADDR
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              scl_i,
  input  logic              sda_i,
  input  logic              start_detect_i,
  input  logic              stop_detect_i,
  input  logic [6:0]        own_addr_i,
  input  logic              own_addr_valid_i,
  bus_rx_framer_if.master   rx_if,
  output logic              addr_match_o,
  output logic              rnw_o,
  output logic              ninth_valid_o,
  output logic              ninth_bit_o,
  output logic              frame_error_o,
  output logic              overflow_o,
  input  logic              overflow_clr_i
`ifdef BUS_RX_FRAMER_PARITY_CHECK_EN
  ,
  output logic              parity_err_o
`endif
);

  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sr_q, sr_d;
  logic       scl_q;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_is_addr_q, rx_is_addr_d;
  logic       rx_valid_q, rx_valid_d;
  logic       addr_match_q, addr_match_d;
  logic       rnw_q, rnw_d;
  logic       ninth_valid_q, ninth_valid_d;
  logic       ninth_bit_q, ninth_bit_d;
  logic       frame_error_q, frame_error_d;
  logic       overflow_q, overflow_d;
`ifdef BUS_RX_FRAMER_PARITY_CHECK_EN
  logic       from_data_q, from_data_d;
  logic       parity_err_q, parity_err_d;
`endif

  logic       scl_rise;
  logic [7:0] shifted;
  logic       in_byte;
  logic       emit;
  logic       emit_is_addr;
  logic       match;

  assign scl_rise = enable_i & ~scl_q & scl_i;
  assign shifted  = {sr_q[6:0], sda_i};
  assign in_byte  = (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign match    = (shifted[7:1] == BROADCAST_ADDR) ||
                    (own_addr_valid_i && (shifted[7:1] == own_addr_i));

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    sr_d          = sr_q;
    addr_match_d  = addr_match_q;
    rnw_d         = rnw_q;
    ninth_bit_d   = ninth_bit_q;
    ninth_valid_d = 1'b0;
    frame_error_d = 1'b0;
    emit          = 1'b0;
    emit_is_addr  = 1'b0;
`ifdef BUS_RX_FRAMER_PARITY_CHECK_EN
    from_data_d   = from_data_q;
    parity_err_d  = 1'b0;
`endif

    if (!enable_i) begin
      state_d      = ST_IDLE;
      bit_cnt_d    = 3'd0;
      addr_match_d = 1'b0;
    end else if (stop_detect_i) begin
      state_d      = ST_IDLE;
      addr_match_d = 1'b0;
      frame_error_d = in_byte && (bit_cnt_q != 3'd0);
    end else if (start_detect_i) begin
      state_d       = ST_ADDR;
      bit_cnt_d     = 3'd0;
      frame_error_d = in_byte && (bit_cnt_q != 3'd0);
    end else if (scl_rise) begin
      case (state_q)
        ST_ADDR, ST_DATA: begin
          sr_d      = shifted;
          // 3-bit counter wraps 7->0 on byte completion
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            emit         = 1'b1;
            emit_is_addr = (state_q == ST_ADDR);
            if (state_q == ST_ADDR) begin
              addr_match_d = match;
              if (match) begin
                rnw_d   = shifted[0];
                state_d = ST_NINTH;
              end else begin
                state_d = ST_IGNORE;
              end
`ifdef BUS_RX_FRAMER_PARITY_CHECK_EN
              from_data_d = 1'b0;
`endif
            end else begin
              state_d = ST_NINTH;
`ifdef BUS_RX_FRAMER_PARITY_CHECK_EN
              from_data_d = 1'b1;
`endif
            end
          end
        end
        ST_NINTH: begin
          ninth_bit_d   = sda_i;
          ninth_valid_d = 1'b1;
          state_d       = ST_DATA;
`ifdef BUS_RX_FRAMER_PARITY_CHECK_EN
          // On writes the 9th bit is the T-bit: odd parity over the byte.
          // sr_q still holds the byte because NINTH does not shift.
          parity_err_d  = from_data_q && !rnw_q && (sda_i != ~^sr_q);
`endif
        end
        default: ;
      endcase
    end
  end

  // Output holding register: a completion coinciding with an accept loads
  // straight through; a completion against an unaccepted byte is dropped.
  always_comb begin
    rx_byte_d    = rx_byte_q;
    rx_is_addr_d = rx_is_addr_q;
    rx_valid_d   = rx_valid_q;
    overflow_d   = overflow_q;
    if (overflow_clr_i) overflow_d = 1'b0;
    if (emit) begin
      if (!rx_valid_q || rx_if.rx_ready_i) begin
        rx_byte_d    = shifted;
        rx_is_addr_d = emit_is_addr;
        rx_valid_d   = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (rx_valid_q && rx_if.rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 3'd0;
      sr_q          <= 8'h00;
      scl_q         <= 1'b1;
      rx_byte_q     <= 8'h00;
      rx_is_addr_q  <= 1'b0;
      rx_valid_q    <= 1'b0;
      addr_match_q  <= 1'b0;
      rnw_q         <= 1'b0;
      ninth_valid_q <= 1'b0;
      ninth_bit_q   <= 1'b0;
      frame_error_q <= 1'b0;
      overflow_q    <= 1'b0;
`ifdef BUS_RX_FRAMER_PARITY_CHECK_EN
      from_data_q   <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      sr_q          <= sr_d;
      scl_q         <= scl_i;
      rx_byte_q     <= rx_byte_d;
      rx_is_addr_q  <= rx_is_addr_d;
      rx_valid_q    <= rx_valid_d;
      addr_match_q  <= addr_match_d;
      rnw_q         <= rnw_d;
      ninth_valid_q <= ninth_valid_d;
      ninth_bit_q   <= ninth_bit_d;
      frame_error_q <= frame_error_d;
      overflow_q    <= overflow_d;
`ifdef BUS_RX_FRAMER_PARITY_CHECK_EN
      from_data_q   <= from_data_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign rx_if.rx_byte_o    = rx_byte_q;
  assign rx_if.rx_is_addr_o = rx_is_addr_q;
  assign rx_if.rx_valid_o   = rx_valid_q;
  assign addr_match_o       = addr_match_q;
  assign rnw_o              = rnw_q;
  assign ninth_valid_o      = ninth_valid_q;
  assign ninth_bit_o        = ninth_bit_q;
  assign frame_error_o      = frame_error_q;
  assign overflow_o         = overflow_q;
`ifdef BUS_RX_FRAMER_PARITY_CHECK_EN
  assign parity_err_o       = parity_err_q;
`endif

endmodule

// File: tb/tb_bus_rx_framer.sv
// Scoreboard bench for bus_rx_framer: directed bus frames push expected bytes
// and 9th bits into queues; monitors pop and compare when the DUT presents them.
// Parity cases are included when BUS_RX_FRAMER_PARITY_CHECK_EN is defined.
module tb_bus_rx_framer;
  import bus_rx_framer_pkg::*;

  localparam int K_START = 0;
  localparam int K_STOP  = 1;
  localparam int K_BIT   = 2;
  localparam int K_BYTE  = 3;

  typedef struct {
    logic [7:0] data;
    logic       is_addr;
    logic       chk_match;
    logic       match;
    logic       rnw;
  } byte_exp_t;

  typedef struct {
    logic bit_val;
    logic perr;
  } ninth_exp_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       enable_i = 1'b0;
  logic       scl_i = 1'b1;
  logic       sda_i = 1'b1;
  logic       start_detect_i = 1'b0;
  logic       stop_detect_i = 1'b0;
  logic [6:0] own_addr_i = 7'h2D;
  logic       own_addr_valid_i = 1'b1;
  logic       addr_match_o, rnw_o, ninth_valid_o, ninth_bit_o;
  logic       frame_error_o, overflow_o;
  logic       overflow_clr_i = 1'b0;
`ifdef BUS_RX_FRAMER_PARITY_CHECK_EN
  logic       parity_err_o;
`endif

  bus_rx_framer_if rx_if ();

  bus_rx_framer dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .enable_i         (enable_i),
    .scl_i            (scl_i),
    .sda_i            (sda_i),
    .start_detect_i   (start_detect_i),
    .stop_detect_i    (stop_detect_i),
    .own_addr_i       (own_addr_i),
    .own_addr_valid_i (own_addr_valid_i),
    .rx_if            (rx_if.master),
    .addr_match_o     (addr_match_o),
    .rnw_o            (rnw_o),
    .ninth_valid_o    (ninth_valid_o),
    .ninth_bit_o      (ninth_bit_o),
    .frame_error_o    (frame_error_o),
    .overflow_o       (overflow_o),
    .overflow_clr_i   (overflow_clr_i)
`ifdef BUS_RX_FRAMER_PARITY_CHECK_EN
    ,
    .parity_err_o     (parity_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int tests_run = 0;
  int tests_failed = 0;
  int fe_seen = 0;
  int fe_expected = 0;
  byte_exp_t  byte_q[$];
  ninth_exp_t ninth_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expectByte(input logic [7:0] d, input logic is_addr, input logic chk, input logic m, input logic r);
    byte_exp_t e;
    e.data = d; e.is_addr = is_addr; e.chk_match = chk; e.match = m; e.rnw = r;
    byte_q.push_back(e);
  endtask

  task automatic expectNinth(input logic b, input logic perr);
    ninth_exp_t e;
    e.bit_val = b; e.perr = perr;
    ninth_q.push_back(e);
  endtask

  task automatic applyStimulus(input int kind, input logic [7:0] val);
    case (kind)
      K_START: begin
        scl_i = 1'b1; start_detect_i = 1'b1; tick(); start_detect_i = 1'b0; tick();
      end
      K_STOP: begin
        scl_i = 1'b1; stop_detect_i = 1'b1; tick(); stop_detect_i = 1'b0; tick();
      end
      K_BIT: begin
        scl_i = 1'b0; sda_i = val[0]; tick(); tick();
        scl_i = 1'b1; tick(); tick();
      end
      default: begin
        for (int i = 7; i >= 0; i--) begin
          scl_i = 1'b0; sda_i = val[i]; tick(); tick();
          scl_i = 1'b1; tick(); tick();
        end
      end
    endcase
  endtask

  // Byte monitor: compares every accepted byte against the scoreboard head.
  always @(negedge clk_i) begin
    if (rst_ni && rx_if.rx_valid_o && rx_if.rx_ready_i) begin
      if (byte_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL rx_unexpected: got byte %0h, required no byte", rx_if.rx_byte_o);
      end else begin
        byte_exp_t e;
        e = byte_q.pop_front();
        checkOutput("rx_byte", {24'd0, rx_if.rx_byte_o}, {24'd0, e.data});
        checkOutput("rx_is_addr", {31'd0, rx_if.rx_is_addr_o}, {31'd0, e.is_addr});
        if (e.chk_match) begin
          checkOutput("addr_match", {31'd0, addr_match_o}, {31'd0, e.match});
          if (e.match) checkOutput("rnw", {31'd0, rnw_o}, {31'd0, e.rnw});
        end
      end
    end
  end

  // Ninth-bit and frame-error monitor.
  always @(negedge clk_i) begin
    if (rst_ni && frame_error_o) fe_seen++;
    if (rst_ni && ninth_valid_o) begin
      if (ninth_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL ninth_unexpected: got bit %0b, required no pulse", ninth_bit_o);
      end else begin
        ninth_exp_t e;
        e = ninth_q.pop_front();
        checkOutput("ninth_bit", {31'd0, ninth_bit_o}, {31'd0, e.bit_val});
`ifdef BUS_RX_FRAMER_PARITY_CHECK_EN
        checkOutput("parity_err", {31'd0, parity_err_o}, {31'd0, e.perr});
`endif
      end
    end
  end

  initial begin
    rx_if.rx_ready_i = 1'b1;
    tick(); tick();
    checkOutput("reset_rx_valid", {31'd0, rx_if.rx_valid_o}, 32'd0);
    checkOutput("reset_rx_byte", {24'd0, rx_if.rx_byte_o}, 32'd0);
    checkOutput("reset_addr_match", {31'd0, addr_match_o}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow_o}, 32'd0);
    checkOutput("reset_ninth_valid", {31'd0, ninth_valid_o}, 32'd0);
    checkOutput("reset_frame_error", {31'd0, frame_error_o}, 32'd0);
    rst_ni = 1'b1;
    enable_i = 1'b1;
    tick(); tick();

    // Own address 0x2D, write, ACK 0
    applyStimulus(K_START, 8'h00);
    expectByte(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(K_BYTE, 8'h5A);
    expectNinth(1'b0, 1'b0);
    applyStimulus(K_BIT, 8'h00);
    checkOutput("match_before_stop", {31'd0, addr_match_o}, 32'd1);
    applyStimulus(K_STOP, 8'h00);
    checkOutput("match_after_stop", {31'd0, addr_match_o}, 32'd0);

    // Broadcast address followed by a data byte
    applyStimulus(K_START, 8'h00);
    expectByte(8'hFC, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(K_BYTE, 8'hFC);
    expectNinth(1'b0, 1'b0);
    applyStimulus(K_BIT, 8'h00);
    expectByte(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(K_BYTE, 8'hA5);
    // ~^A5 = 1, so T=1 is correct parity
    expectNinth(1'b1, 1'b0);
    applyStimulus(K_BIT, 8'h01);
    applyStimulus(K_STOP, 8'h00);

    // Non-matching address: only the address byte appears
    applyStimulus(K_START, 8'h00);
    expectByte(8'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(K_BYTE, 8'h40);
    applyStimulus(K_BIT, 8'h00);
    applyStimulus(K_BYTE, 8'h33);
    applyStimulus(K_BIT, 8'h00);
    checkOutput("ignore_match", {31'd0, addr_match_o}, 32'd0);
    checkOutput("ignore_no_valid", {31'd0, rx_if.rx_valid_o}, 32'd0);
    applyStimulus(K_STOP, 8'h00);

    // Read address sets rnw
    applyStimulus(K_START, 8'h00);
    expectByte(8'h5B, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(K_BYTE, 8'h5B);
    expectNinth(1'b0, 1'b0);
    applyStimulus(K_BIT, 8'h00);
    applyStimulus(K_STOP, 8'h00);
    checkOutput("fe_none_yet", fe_seen, 32'd0);

    // Repeated START after 4 data bits
    applyStimulus(K_START, 8'h00);
    expectByte(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(K_BYTE, 8'h5A);
    expectNinth(1'b0, 1'b0);
    applyStimulus(K_BIT, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(K_BIT, 8'h01);
    fe_expected++;
    applyStimulus(K_START, 8'h00);
    expectByte(8'h5B, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(K_BYTE, 8'h5B);
    expectNinth(1'b1, 1'b0);
    applyStimulus(K_BIT, 8'h01);
    applyStimulus(K_STOP, 8'h00);
    checkOutput("frame_error_count", fe_seen, fe_expected);

    // Overflow: consumer stalls across two data bytes
    applyStimulus(K_START, 8'h00);
    expectByte(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(K_BYTE, 8'h5A);
    expectNinth(1'b0, 1'b0);
    applyStimulus(K_BIT, 8'h00);
    rx_if.rx_ready_i = 1'b0;
    expectByte(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(K_BYTE, 8'h11);
    // ~^11 = 1
    expectNinth(1'b1, 1'b0);
    applyStimulus(K_BIT, 8'h01);
    checkOutput("ovf_not_yet", {31'd0, overflow_o}, 32'd0);
    applyStimulus(K_BYTE, 8'h22);
    expectNinth(1'b1, 1'b0);
    applyStimulus(K_BIT, 8'h01);
    checkOutput("ovf_set", {31'd0, overflow_o}, 32'd1);
    checkOutput("ovf_held_valid", {31'd0, rx_if.rx_valid_o}, 32'd1);
    checkOutput("ovf_held_byte", {24'd0, rx_if.rx_byte_o}, 32'h11);
    rx_if.rx_ready_i = 1'b1;
    tick(); tick();
    checkOutput("ovf_valid_drop", {31'd0, rx_if.rx_valid_o}, 32'd0);
    checkOutput("ovf_sticky", {31'd0, overflow_o}, 32'd1);
    overflow_clr_i = 1'b1;
    tick();
    overflow_clr_i = 1'b0;
    checkOutput("ovf_cleared", {31'd0, overflow_o}, 32'd0);
    applyStimulus(K_STOP, 8'h00);

`ifdef BUS_RX_FRAMER_PARITY_CHECK_EN
    // Odd parity: ~^8'h01 = 0, so T=1 is an error and T=0 is not
    applyStimulus(K_START, 8'h00);
    expectByte(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(K_BYTE, 8'h5A);
    expectNinth(1'b0, 1'b0);
    applyStimulus(K_BIT, 8'h00);
    expectByte(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(K_BYTE, 8'h01);
    expectNinth(1'b1, 1'b1);
    applyStimulus(K_BIT, 8'h01);
    expectByte(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(K_BYTE, 8'h01);
    expectNinth(1'b0, 1'b0);
    applyStimulus(K_BIT, 8'h00);
    applyStimulus(K_STOP, 8'h00);
`endif

    for (int i = 0; i < 20; i++) tick();
    checkOutput("byte_queue_drained", byte_q.size(), 32'd0);
    checkOutput("ninth_queue_drained", ninth_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
